ahblite_interconnect_slaveport_arbiter: RTL and testbench
=========================================================

// Module: ahblite_interconnect_slaveport_arbiter
// PURPOSE
//  Per-slave arbiter in the AHB-Lite interconnect. Shares one slave port among MASTER masterports.
//  Grants the address phase to one master and holds the grant across defined-length bursts (and
//  locked sequences when enabled). Tracks which master owns the data phase so HRDATA/HREADY/HRESP
//  are steered back correctly.
//  Sits between the masterports' HSEL/command outputs and the slaveport mux.
// PARAMETERS
//  MASTER      2   number of requesting masterports (>=2)
//  MIDX_W      $clog2(MASTER)  index width (localparam)
// PORTS
//  HCLK             in   1              clock
//  HRESET           in   1              asynchronous reset, active-high
//  mst_req_i        in   MASTER         master m selects this slave and HTRANS[m]!=IDLE
//  mst_HTRANS_i     in   MASTER x 2     per-master HTRANS
//  mst_HBURST_i     in   MASTER x 3     per-master HBURST
//  mst_HMASTLOCK_i  in   MASTER         per-master HMASTLOCK
//  slv_HREADYOUT_i  in   1              slave ready; transfer boundary when 1
//  addr_grant_o     out  MASTER         one-hot address-phase grant
//  addr_sel_o       out  MIDX_W         index of granted master (command mux select)
//  data_sel_o       out  MIDX_W         index of data-phase owner (HWDATA/HRDATA mux select)
//  data_valid_o     out  1              a granted NONSEQ/SEQ is in data phase
//  mst_wait_o       out  MASTER         requesting but not granted: masterport holds command
// BEHAVIOUR
//  Reset: addr_grant_o=0, addr_sel_o=0, data_sel_o=0, data_valid_o=0, mst_wait_o=0.
//  Reset: state=ARB, burst_cnt=0, rr_ptr=MASTER-1 (master 0 wins first).
//  All state updates occur only when slv_HREADYOUT_i=1; when 0, every register holds.
//  FSM states:
//    ARB    no owner or owner at boundary; pick winner, 0-cycle combinational grant.
//    BURST  owner mid defined-length burst; grant locked to owner.
//    LOCK   owner asserting HMASTLOCK; grant locked (macro only).
//  Round-robin: the winner is the first requester after rr_ptr, modulo MASTER.
//    On each NONSEQ accepted from the winner, rr_ptr<=winner.
//  Burst count:
//    On accepted NONSEQ, burst_cnt<=SINGLE:0, INCR:0, WRAP4/INCR4:3, WRAP8/INCR8:7, WRAP16/INCR16:15.
//    ARB->BURST if that value !=0.
//  In BURST: accepted SEQ decrements burst_cnt; BUSY holds; BURST->ARB when burst_cnt reaches 0.
//    Owner IDLE (early termination) -> ARB, cnt<=0.
//  INCR (undefined) never enters BURST; rearbitration at each NONSEQ/IDLE boundary.
//  addr_grant_o/addr_sel_o are combinational in ARB, registered owner otherwise.
//    No grant (all 0, sel holds) when no request.
//  data_sel_o<=addr_sel_o and data_valid_o<=|(addr_grant_o & mst_req_i) on each HREADYOUT=1 edge.
//  mst_wait_o = mst_req_i & ~addr_grant_o.
//  Simultaneous requests: round-robin only. Requester dropping mid-burst (protocol error): grant held until cnt=0 or IDLE.
//  HRESET mid-burst: immediate return to reset values; no partial beat tracked.
// CONFIGURATION
//  AHBLITE_ARB_MASTLOCK_EN defined:
//    A winner with HMASTLOCK=1 at NONSEQ enters LOCK.
//    LOCK holds grant irrespective of burst_cnt until the owner issues a transfer with HMASTLOCK=0 or IDLE.
//    Then LOCK->ARB (or BURST if that NONSEQ starts a defined burst).
//  Not defined: mst_HMASTLOCK_i ignored; LOCK state absent.
// STRUCTURE
//  ahblite_pkg holds:
//    htrans_e {IDLE=2'b00,BUSY=2'b01,NONSEQ=2'b10,SEQ=2'b11}
//    hburst_e {SINGLE,INCR,WRAP4,INCR4,WRAP8,INCR8,WRAP16,INCR16}
//    arb_state_e {ARB,BURST,LOCK}
//    function burst_len(hburst_e)->4b
//  Sub-module ahblite_rr_picker: combinational (req[MASTER], ptr) -> one-hot gnt + idx.
// TESTING
//  1 M0,M1 both SINGLE NONSEQ every cycle, HREADYOUT=1 -> grants alternate M0,M1,M0; data_sel lags addr_sel by 1.
//  2 M0 INCR4 while M1 requests -> M0 holds 4 beats; M1 granted cycle after 4th beat; mst_wait_o[1]=1 throughout.
//  3 HREADYOUT=0 for 3 cycles mid WRAP8 -> grant, burst_cnt, data_sel frozen; resumes at same count.
//  4 M1 WRAP4 terminated by IDLE after beat 2 -> ARB next boundary; M0 granted.
//  5 HRESET pulse mid INCR16 -> all outputs 0 asynchronously; after release M0 wins first.
//  6 (MASTLOCK_EN) M0 locked two SINGLEs, M1 requesting -> M1 waits until M0 drops HMASTLOCK; without macro -> alternates.

Source files
------------

// File: rtl/ahblite_pkg.sv
// Shared types for the AHB-Lite interconnect slave-port arbiter.
package ahblite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    BURST = 2'd1,
    LOCK  = 2'd2
  } arb_state_e;

  // Beats remaining after the NONSEQ of a burst; 0 means the grant is not held.
  function automatic logic [3:0] burst_len(hburst_e b);
    case (b)
      WRAP4, INCR4:   burst_len = 4'd3;
      WRAP8, INCR8:   burst_len = 4'd7;
      WRAP16, INCR16: burst_len = 4'd15;
      default:        burst_len = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahblite_rr_picker.sv
// Combinational round-robin picker: first requester strictly after i_ptr, wrapping.
module ahblite_rr_picker #(
  parameter int MASTER = 2,
  parameter int MIDX_W = 1
) (
  input  logic [MASTER-1:0] i_req,
  input  logic [MIDX_W-1:0] i_ptr,
  output logic [MASTER-1:0] o_gnt,
  output logic [MIDX_W-1:0] o_idx,
  output logic              o_any
);

  // Scan candidates ptr+1 .. ptr+MASTER; the first hit wins.
  always_comb begin
    int w_cand;
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = 0;
    for (int i = 1; i <= MASTER; i++) begin
      w_cand = (int'(i_ptr) + i) % MASTER;
      if (!o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = MIDX_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/ahblite_interconnect_slaveport_arbiter.sv
// Per-slave arbiter: round-robin address-phase grant, held across defined-length
// bursts, with data-phase owner tracking. Optional feature macro:
// AHBLITE_ARB_MASTLOCK_EN adds the LOCK state that holds the grant while HMASTLOCK=1.
// Handshake: every register advances only on a cycle where slv_HREADYOUT_i=1
// (transfer boundary); with slv_HREADYOUT_i=0 all state holds and the address
// phase presented by the granted master is stalled.
module ahblite_interconnect_slaveport_arbiter
  import ahblite_pkg::*;
#(
  parameter  int MASTER = 2,
  localparam int MIDX_W = $clog2(MASTER)
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [MASTER-1:0]      mst_req_i,
  input  logic [MASTER-1:0][1:0] mst_HTRANS_i,
  input  logic [MASTER-1:0][2:0] mst_HBURST_i,
  input  logic [MASTER-1:0]      mst_HMASTLOCK_i,
  input  logic                   slv_HREADYOUT_i,
  output logic [MASTER-1:0]      addr_grant_o,
  output logic [MIDX_W-1:0]      addr_sel_o,
  output logic [MIDX_W-1:0]      data_sel_o,
  output logic                   data_valid_o,
  output logic [MASTER-1:0]      mst_wait_o,
  output logic [1:0]             dbg_state_o
);

  arb_state_e        r_state, w_state_nxt;
  logic [3:0]        r_burst_cnt, w_cnt_nxt;
  logic [MIDX_W-1:0] r_rr_ptr, w_ptr_nxt;
  logic [MIDX_W-1:0] r_owner, w_owner_nxt;
  logic [MIDX_W-1:0] r_data_sel;
  logic              r_data_valid;

  logic [MASTER-1:0] w_pick_gnt, w_own_gnt, w_grant;
  logic [MIDX_W-1:0] w_pick_idx, w_sel;
  logic              w_pick_any;
  htrans_e           w_pick_trans, w_own_trans;
  hburst_e           w_pick_burst, w_own_burst;
  logic              w_unused_lock;

  ahblite_rr_picker #(.MASTER(MASTER), .MIDX_W(MIDX_W)) u_picker (
    .i_req (mst_req_i),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  assign w_pick_trans  = htrans_e'(mst_HTRANS_i[w_pick_idx]);
  assign w_pick_burst  = hburst_e'(mst_HBURST_i[w_pick_idx]);
  assign w_own_trans   = htrans_e'(mst_HTRANS_i[r_owner]);
  assign w_own_burst   = hburst_e'(mst_HBURST_i[r_owner]);
  assign w_own_gnt     = MASTER'(1) << r_owner;
  assign w_unused_lock = ^mst_HMASTLOCK_i;

  // Next-state and grant selection; ARB grants combinationally, other states hold the owner.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_burst_cnt;
    w_ptr_nxt   = r_rr_ptr;
    w_owner_nxt = r_owner;
    w_grant     = '0;
    w_sel       = r_owner;
    case (r_state)
      ARB: begin
        if (w_pick_any) begin
          w_grant     = w_pick_gnt;
          w_sel       = w_pick_idx;
          w_owner_nxt = w_pick_idx;
          if (w_pick_trans == NONSEQ) begin
            w_ptr_nxt = w_pick_idx;
            w_cnt_nxt = burst_len(w_pick_burst);
`ifdef AHBLITE_ARB_MASTLOCK_EN
            if (mst_HMASTLOCK_i[w_pick_idx]) w_state_nxt = LOCK;
            else
`endif
            if (burst_len(w_pick_burst) != 4'd0) w_state_nxt = BURST;
          end
        end
      end
      BURST: begin
        w_grant = w_own_gnt;
        case (w_own_trans)
          SEQ: begin
            if (r_burst_cnt != 4'd0) w_cnt_nxt = r_burst_cnt - 4'd1;
            if (r_burst_cnt <= 4'd1) w_state_nxt = ARB;
          end
          IDLE: begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = ARB;
          end
          NONSEQ: begin
            // Owner restarted without finishing: treat as a fresh accepted NONSEQ.
            w_ptr_nxt   = r_owner;
            w_cnt_nxt   = burst_len(w_own_burst);
            w_state_nxt = (burst_len(w_own_burst) != 4'd0) ? BURST : ARB;
          end
          default: ;
        endcase
      end
`ifdef AHBLITE_ARB_MASTLOCK_EN
      LOCK: begin
        w_grant = w_own_gnt;
        if (w_own_trans == IDLE) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ARB;
        end else if (w_own_trans == NONSEQ) begin
          w_ptr_nxt = r_owner;
          w_cnt_nxt = burst_len(w_own_burst);
          if (!mst_HMASTLOCK_i[r_owner])
            w_state_nxt = (burst_len(w_own_burst) != 4'd0) ? BURST : ARB;
        end else if (!mst_HMASTLOCK_i[r_owner]) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ARB;
        end else if (w_own_trans == SEQ && r_burst_cnt != 4'd0) begin
          w_cnt_nxt = r_burst_cnt - 4'd1;
        end
      end
`endif
      default: w_state_nxt = ARB;
    endcase
  end

  // State registers advance only at transfer boundaries.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state      <= ARB;
      r_burst_cnt  <= 4'd0;
      r_rr_ptr     <= MIDX_W'(MASTER - 1);
      r_owner      <= '0;
      r_data_sel   <= '0;
      r_data_valid <= 1'b0;
    end else if (slv_HREADYOUT_i) begin
      r_state      <= w_state_nxt;
      r_burst_cnt  <= w_cnt_nxt;
      r_rr_ptr     <= w_ptr_nxt;
      r_owner      <= w_owner_nxt;
      r_data_sel   <= w_sel;
      r_data_valid <= |(w_grant & mst_req_i);
    end
  end

  // Outputs are forced low while reset is asserted so the grant drops asynchronously.
  assign addr_grant_o = HRESET ? '0 : w_grant;
  assign addr_sel_o   = HRESET ? '0 : w_sel;
  assign mst_wait_o   = HRESET ? '0 : (mst_req_i & ~w_grant);
  assign data_sel_o   = r_data_sel;
  assign data_valid_o = r_data_valid;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_ahblite_interconnect_slaveport_arbiter.sv
// Directed vector bench for the slave-port arbiter (MASTER=2).
module tb_ahblite_interconnect_slaveport_arbiter;

  localparam logic [1:0] T_I = 2'b00, T_B = 2'b01, T_N = 2'b10, T_S = 2'b11;
  localparam logic [2:0] B_SGL = 3'd0, B_W4 = 3'd2, B_I4 = 3'd3, B_W8 = 3'd4, B_I16 = 3'd7;
  localparam logic [1:0] S_ARB = 2'd0, S_BST = 2'd1, S_LCK = 2'd2;

  logic            HCLK = 1'b0;
  logic            HRESET;
  logic [1:0]      mst_req_i;
  logic [1:0][1:0] mst_HTRANS_i;
  logic [1:0][2:0] mst_HBURST_i;
  logic [1:0]      mst_HMASTLOCK_i;
  logic            slv_HREADYOUT_i;
  logic [1:0]      addr_grant_o;
  logic            addr_sel_o;
  logic            data_sel_o;
  logic            data_valid_o;
  logic [1:0]      mst_wait_o;
  logic [1:0]      dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;

  ahblite_interconnect_slaveport_arbiter #(.MASTER(2)) dut (
    .HCLK            (HCLK),
    .HRESET          (HRESET),
    .mst_req_i       (mst_req_i),
    .mst_HTRANS_i    (mst_HTRANS_i),
    .mst_HBURST_i    (mst_HBURST_i),
    .mst_HMASTLOCK_i (mst_HMASTLOCK_i),
    .slv_HREADYOUT_i (slv_HREADYOUT_i),
    .addr_grant_o    (addr_grant_o),
    .addr_sel_o      (addr_sel_o),
    .data_sel_o      (data_sel_o),
    .data_valid_o    (data_valid_o),
    .mst_wait_o      (mst_wait_o),
    .dbg_state_o     (dbg_state_o)
  );

  // Clock and safety timeout.
  always #5 HCLK = ~HCLK;
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish (got running, want finished)");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       rdy;
    logic [1:0] req;
    logic [1:0] t0, t1;
    logic [2:0] b0, b1;
    logic [1:0] lk;
    logic [1:0] e_gnt;
    logic       e_sel, e_dsel, e_dval;
    logic [1:0] e_wait, e_st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rdy, input logic [1:0] req, input logic [1:0] t0, t1,
                     input logic [2:0] b0, b1, input logic [1:0] lk,
                     input logic [1:0] e_gnt, input logic e_sel, e_dsel, e_dval,
                     input logic [1:0] e_wait, e_st);
    vec_t v;
    v.rdy = rdy; v.req = req; v.t0 = t0; v.t1 = t1; v.b0 = b0; v.b1 = b1; v.lk = lk;
    v.e_gnt = e_gnt; v.e_sel = e_sel; v.e_dsel = e_dsel; v.e_dval = e_dval;
    v.e_wait = e_wait; v.e_st = e_st;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] gnt, input logic sel, dsel, dval,
                           input logic [1:0] wt, st);
    check({tag, ".grant"}, {2'b0, addr_grant_o}, {2'b0, gnt});
    check({tag, ".sel"},   {3'b0, addr_sel_o},   {3'b0, sel});
    check({tag, ".dsel"},  {3'b0, data_sel_o},   {3'b0, dsel});
    check({tag, ".dval"},  {3'b0, data_valid_o}, {3'b0, dval});
    check({tag, ".wait"},  {2'b0, mst_wait_o},   {2'b0, wt});
    check({tag, ".state"}, {2'b0, dbg_state_o},  {2'b0, st});
  endtask

  task automatic drive(input logic rdy, input logic [1:0] req, input logic [1:0] t0, t1,
                       input logic [2:0] b0, b1, input logic [1:0] lk);
    slv_HREADYOUT_i = rdy;
    mst_req_i       = req;
    mst_HTRANS_i    = {t1, t0};
    mst_HBURST_i    = {b1, b0};
    mst_HMASTLOCK_i = lk;
  endtask

  initial begin
    // Columns: rdy req t0 t1 b0 b1 lk | gnt sel dsel dval wait state
    // 1: both SINGLE every cycle -> alternate M0,M1,M0
    add(1, 2'b11, T_N, T_N, B_SGL, B_SGL, 2'b00, 2'b01, 0, 0, 0, 2'b10, S_ARB);
    add(1, 2'b11, T_N, T_N, B_SGL, B_SGL, 2'b00, 2'b10, 1, 0, 1, 2'b01, S_ARB);
    add(1, 2'b11, T_N, T_N, B_SGL, B_SGL, 2'b00, 2'b01, 0, 1, 1, 2'b10, S_ARB);
    add(1, 2'b10, T_I, T_N, B_SGL, B_SGL, 2'b00, 2'b10, 1, 0, 1, 2'b00, S_ARB);
    // 2: M0 INCR4 while M1 waits; M1 wins right after the 4th beat
    add(1, 2'b11, T_N, T_N, B_I4,  B_SGL, 2'b00, 2'b01, 0, 1, 1, 2'b10, S_ARB);
    add(1, 2'b11, T_S, T_N, B_I4,  B_SGL, 2'b00, 2'b01, 0, 0, 1, 2'b10, S_BST);
    add(1, 2'b11, T_S, T_N, B_I4,  B_SGL, 2'b00, 2'b01, 0, 0, 1, 2'b10, S_BST);
    add(1, 2'b11, T_S, T_N, B_I4,  B_SGL, 2'b00, 2'b01, 0, 0, 1, 2'b10, S_BST);
    add(1, 2'b11, T_N, T_N, B_SGL, B_SGL, 2'b00, 2'b10, 1, 0, 1, 2'b01, S_ARB);
    // 3: M0 WRAP8 with 3 stall cycles; 7 accepted SEQ beats end the burst
    add(1, 2'b01, T_N, T_I, B_W8,  B_SGL, 2'b00, 2'b01, 0, 1, 1, 2'b00, S_ARB);
    add(1, 2'b01, T_S, T_I, B_W8,  B_SGL, 2'b00, 2'b01, 0, 0, 1, 2'b00, S_BST);
    add(0, 2'b01, T_S, T_I, B_W8,  B_SGL, 2'b00, 2'b01, 0, 0, 1, 2'b00, S_BST);
    add(0, 2'b11, T_S, T_N, B_W8,  B_SGL, 2'b00, 2'b01, 0, 0, 1, 2'b10, S_BST);
    add(0, 2'b11, T_S, T_N, B_W8,  B_SGL, 2'b00, 2'b01, 0, 0, 1, 2'b10, S_BST);
    for (int i = 0; i < 6; i++)
      add(1, 2'b01, T_S, T_I, B_W8, B_SGL, 2'b00, 2'b01, 0, 0, 1, 2'b00, S_BST);
    // 4: M1 WRAP4 cut short by IDLE after 2 beats; M0 granted next
    add(1, 2'b10, T_I, T_N, B_SGL, B_W4,  2'b00, 2'b10, 1, 0, 1, 2'b00, S_ARB);
    add(1, 2'b11, T_N, T_S, B_SGL, B_W4,  2'b00, 2'b10, 1, 1, 1, 2'b01, S_BST);
    add(1, 2'b01, T_N, T_I, B_SGL, B_W4,  2'b00, 2'b10, 1, 1, 1, 2'b01, S_BST);
    add(1, 2'b01, T_N, T_I, B_SGL, B_SGL, 2'b00, 2'b01, 0, 1, 0, 2'b00, S_ARB);
    // 6: M0 two locked SINGLEs then unlocked, M1 requesting throughout
    add(1, 2'b10, T_I, T_N, B_SGL, B_SGL, 2'b00, 2'b10, 1, 0, 1, 2'b00, S_ARB);
    add(1, 2'b11, T_N, T_N, B_SGL, B_SGL, 2'b01, 2'b01, 0, 1, 1, 2'b10, S_ARB);
`ifdef AHBLITE_ARB_MASTLOCK_EN
    add(1, 2'b11, T_N, T_N, B_SGL, B_SGL, 2'b01, 2'b01, 0, 0, 1, 2'b10, S_LCK);
    add(1, 2'b11, T_N, T_N, B_SGL, B_SGL, 2'b00, 2'b01, 0, 0, 1, 2'b10, S_LCK);
`else
    add(1, 2'b11, T_N, T_N, B_SGL, B_SGL, 2'b01, 2'b10, 1, 0, 1, 2'b01, S_ARB);
    add(1, 2'b11, T_N, T_N, B_SGL, B_SGL, 2'b00, 2'b01, 0, 1, 1, 2'b10, S_ARB);
`endif
    add(1, 2'b11, T_N, T_N, B_SGL, B_SGL, 2'b00, 2'b10, 1, 0, 1, 2'b01, S_ARB);

    // Reset state
    HRESET = 1'b1;
    drive(1, 2'b00, T_I, T_I, B_SGL, B_SGL, 2'b00);
    repeat (2) @(negedge HCLK);
    #1 check_all("reset", 2'b00, 0, 0, 0, 2'b00, S_ARB);
    @(negedge HCLK);
    HRESET = 1'b0;

    // Table
    foreach (vecs[k]) begin
      @(negedge HCLK);
      drive(vecs[k].rdy, vecs[k].req, vecs[k].t0, vecs[k].t1, vecs[k].b0, vecs[k].b1, vecs[k].lk);
      #1 check_all($sformatf("vec%0d", k), vecs[k].e_gnt, vecs[k].e_sel, vecs[k].e_dsel,
                   vecs[k].e_dval, vecs[k].e_wait, vecs[k].e_st);
    end

    // 5: reset pulse mid INCR16 (rr pointer is at M1 here, so M0 wins)
    @(negedge HCLK);
    drive(1, 2'b01, T_N, T_I, B_I16, B_SGL, 2'b00);
    #1 check_all("i16.start", 2'b01, 0, 1, 1, 2'b00, S_ARB);
    @(negedge HCLK);
    drive(1, 2'b01, T_S, T_I, B_I16, B_SGL, 2'b00);
    #1 check_all("i16.beat", 2'b01, 0, 0, 1, 2'b00, S_BST);
    @(posedge HCLK);
    #2 HRESET = 1'b1;
    #1 check_all("i16.rst", 2'b00, 0, 0, 0, 2'b00, S_ARB);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    drive(1, 2'b11, T_N, T_N, B_SGL, B_SGL, 2'b00);
    #1 check_all("post_rst", 2'b01, 0, 0, 0, 2'b10, S_ARB);
    @(negedge HCLK);
    #1 check_all("post_rst2", 2'b10, 1, 0, 1, 2'b01, S_ARB);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
